// File: rtl/simon_autoplayer_pkg.sv
// Shared constants, state encoding and mode decode for the Simon autoplayer.
package simon_autoplayer_pkg;

  localparam int PATTERN_W = 4;

  localparam logic [2:0] MODE_INPUT  = 3'b001;
  localparam logic [2:0] MODE_PLAY   = 3'b010;
  localparam logic [2:0] MODE_REPEAT = 3'b100;
  localparam logic [2:0] MODE_DONE   = 3'b111;

  typedef enum logic [1:0] {
    S_INPUT   = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPLAY  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Unrecognised mode_leds codes collapse to the Done state.
  function automatic state_t decode_mode(input logic [2:0] mode);
    case (mode)
      MODE_INPUT:  decode_mode = S_INPUT;
      MODE_PLAY:   decode_mode = S_CAPTURE;
      MODE_REPEAT: decode_mode = S_REPLAY;
      default:     decode_mode = S_DONE;
    endcase
  endfunction

endpackage

// File: rtl/simon_capture_buf.sv
// DEPTH x PATTERN_W register array: synchronous write, asynchronous read.
module simon_capture_buf
  import simon_autoplayer_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                 pclk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PATTERN_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PATTERN_W-1:0] rd_data
);

  logic [PATTERN_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simon_autoplayer.sv
// Records Simon's playback on pattern_leds and replays it during the repeat phase.
// Optional macro AUTOPLAY_ERR_INJECT_EN adds err_inject/err_index to corrupt one replay entry.
module simon_autoplayer
  import simon_autoplayer_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                 pclk,
  input  logic                 rst,
`ifdef AUTOPLAY_ERR_INJECT_EN
  input  logic                 err_inject,
  input  logic [ADDR_W-1:0]    err_index,
`endif
  input  logic [PATTERN_W-1:0] host_pattern,
  input  logic                 host_level,
  input  logic [PATTERN_W-1:0] sim_pattern_leds,
  input  logic [2:0]           sim_mode_leds,
  output logic [PATTERN_W-1:0] pattern,
  output logic                 level,
  output logic [ADDR_W:0]      seq_len,
  output logic [7:0]           round_count,
  output logic                 overflow,
  output logic                 underrun
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t               state_q, state_d, cur_state;
  logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      seq_len_q, seq_len_d;
  logic [7:0]           round_count_q, round_count_d;
  logic                 overflow_q, overflow_d, underrun_q, underrun_d;
  logic                 entry, wr_en, past_end;
  logic [ADDR_W:0]      wp, rp;
  logic [PATTERN_W-1:0] rd_data, replay_val, pattern_mux;

  simon_capture_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .pclk    (pclk),
    .wr_en   (wr_en),
    .wr_addr (wp[ADDR_W-1:0]),
    .wr_data (sim_pattern_leds),
    .rd_addr (rp[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    // The live state tracks the mode directly so replay has zero latency;
    // state_q only remembers last cycle's state to detect entries.
    cur_state     = rst ? S_INPUT : decode_mode(sim_mode_leds);
    entry         = (cur_state != state_q);
    wp            = entry ? '0 : wr_ptr_q;
    rp            = entry ? '0 : rd_ptr_q;
    past_end      = (rp >= seq_len_q);
    state_d       = cur_state;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    seq_len_d     = seq_len_q;
    round_count_d = round_count_q;
    overflow_d    = overflow_q;
    underrun_d    = underrun_q;
    wr_en         = 1'b0;
    replay_val    = rd_data;
`ifdef AUTOPLAY_ERR_INJECT_EN
    if (err_inject && (rp == {1'b0, err_index})) replay_val = rd_data ^ 4'b0001;
`endif
    case (cur_state)
      S_CAPTURE: begin
        if (wp < DEPTH_L) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wp + 1'b1;
          seq_len_d = wp + 1'b1;
        end else begin
          wr_ptr_d   = wp;
          seq_len_d  = DEPTH_L;
          overflow_d = 1'b1;
        end
      end
      S_REPLAY: begin
        if (past_end) underrun_d = 1'b1;
        // Saturate so a long repeat phase can never wrap back into valid entries.
        rd_ptr_d = (rp != '1) ? rp + 1'b1 : rp;
        if (state_q == S_CAPTURE) round_count_d = round_count_q + 8'd1;
      end
      S_INPUT: begin
        if (state_q == S_DONE) begin
          seq_len_d     = '0;
          round_count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cur_state)
      S_INPUT:  pattern_mux = host_pattern;
      S_REPLAY: pattern_mux = past_end ? 4'b0000 : replay_val;
      default:  pattern_mux = 4'b0000;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INPUT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      seq_len_q     <= '0;
      round_count_q <= '0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      seq_len_q     <= seq_len_d;
      round_count_q <= round_count_d;
      overflow_q    <= overflow_d;
      underrun_q    <= underrun_d;
    end
  end

  assign pattern     = pattern_mux;
  assign level       = host_level;
  assign seq_len     = seq_len_q;
  assign round_count = round_count_q;
  assign overflow    = overflow_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: capture, replay, overflow, underrun, done and reset.
module tb_simon_autoplayer;
  import simon_autoplayer_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              pclk = 1'b0;
  logic              rst;
  logic [3:0]        host_pattern;
  logic              host_level;
  logic [3:0]        sim_pattern_leds;
  logic [2:0]        sim_mode_leds;
  logic [3:0]        pattern;
  logic              level;
  logic [ADDR_W:0]   seq_len;
  logic [7:0]        round_count;
  logic              overflow;
  logic              underrun;
`ifdef AUTOPLAY_ERR_INJECT_EN
  logic              err_inject;
  logic [ADDR_W-1:0] err_index;
`endif

  int errors = 0;
  int checks = 0;

  simon_autoplayer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .pclk             (pclk),
    .rst              (rst),
`ifdef AUTOPLAY_ERR_INJECT_EN
    .err_inject       (err_inject),
    .err_index        (err_index),
`endif
    .host_pattern     (host_pattern),
    .host_level       (host_level),
    .sim_pattern_leds (sim_pattern_leds),
    .sim_mode_leds    (sim_mode_leds),
    .pattern          (pattern),
    .level            (level),
    .seq_len          (seq_len),
    .round_count      (round_count),
    .overflow         (overflow),
    .underrun         (underrun)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [3:0] p);
    sim_mode_leds    = m;
    sim_pattern_leds = p;
    #1;
  endtask

  initial begin
    logic [3:0] grow [4];
    grow[0] = 4'b0001; grow[1] = 4'b0100; grow[2] = 4'b1000; grow[3] = 4'b0010;
    rst = 1'b1;
    host_pattern = 4'b1010;
    host_level = 1'b0;
    sim_mode_leds = MODE_INPUT;
    sim_pattern_leds = 4'b0000;
`ifdef AUTOPLAY_ERR_INJECT_EN
    err_inject = 1'b0;
    err_index = '0;
`endif

    // Reset
    repeat (2) cyc();
    check("rst_pattern", 32'(pattern), 32'h a);
    check("rst_seq_len", 32'(seq_len), 0);
    check("rst_round", 32'(round_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst = 1'b0;
    cyc();
    check("input_pass", 32'(pattern), 32'h a);
    host_level = 1'b1;
    #1;
    check("level_pass", 32'(level), 1);

    // Single round
    drive(MODE_PLAY, 4'b0001);
    check("capture_zero", 32'(pattern), 0);
    cyc();
    drive(MODE_PLAY, 4'b0100);
    cyc();
    drive(MODE_PLAY, 4'b1000);
    cyc();
    check("r1_seq_len", 32'(seq_len), 3);
    check("r1_round_pre", 32'(round_count), 0);
    drive(MODE_REPEAT, 4'b0000);
    check("r1_rep0", 32'(pattern), 4'b0001);
    cyc();
    check("r1_round", 32'(round_count), 1);
    check("r1_rep1", 32'(pattern), 4'b0100);
    cyc();
    check("r1_rep2", 32'(pattern), 4'b1000);
    cyc();
    check("r1_underrun", 32'(underrun), 0);

    // Growing game: straight from repeat back into play
    for (int k = 0; k < 4; k++) begin
      drive(MODE_PLAY, grow[k]);
      cyc();
    end
    check("r2_seq_len", 32'(seq_len), 4);
    drive(MODE_REPEAT, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r2_rep%0d", k), 32'(pattern), 32'(grow[k]));
      cyc();
    end
    check("r2_round", 32'(round_count), 2);
    check("r2_underrun", 32'(underrun), 0);

    // Overflow: 64 valid captures then 3 dropped cycles driving zero
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(MODE_PLAY, (i < DEPTH) ? 4'((i % 15) + 1) : 4'b0000);
      cyc();
    end
    check("ov_seq_len", 32'(seq_len), 64);
    check("ov_flag", 32'(overflow), 1);
    drive(MODE_REPEAT, 4'b0000);
    check("ov_rep0", 32'(pattern), 1);
    cyc();
    repeat (62) cyc();
    check("ov_rep63", 32'(pattern), 4);
    cyc();
    check("ov_underrun", 32'(underrun), 0);
    check("ov_round", 32'(round_count), 3);

    // Underrun then done
    drive(MODE_PLAY, 4'b0110);
    cyc();
    drive(MODE_PLAY, 4'b1001);
    cyc();
    check("ur_seq_len", 32'(seq_len), 2);
    drive(MODE_REPEAT, 4'b0000);
    check("ur_rep0", 32'(pattern), 4'b0110);
    cyc();
    check("ur_rep1", 32'(pattern), 4'b1001);
    cyc();
    check("ur_rep2", 32'(pattern), 0);
    cyc();
    check("ur_flag", 32'(underrun), 1);
    drive(MODE_DONE, 4'b0000);
    check("done_pattern", 32'(pattern), 0);
    check("done_round", 32'(round_count), 4);
    cyc();
    drive(3'b011, 4'b1111);
    check("bad_mode", 32'(pattern), 0);
    cyc();
    host_pattern = 4'b0011;
    drive(MODE_INPUT, 4'b0000);
    check("newgame_pat", 32'(pattern), 4'b0011);
    cyc();
    check("newgame_len", 32'(seq_len), 0);
    check("newgame_round", 32'(round_count), 0);
    check("sticky_ov", 32'(overflow), 1);
    check("sticky_ur", 32'(underrun), 1);

    // Asynchronous reset in the middle of a replay
    drive(MODE_PLAY, 4'b1100);
    cyc();
    drive(MODE_REPEAT, 4'b0000);
    check("pre_rst_rep", 32'(pattern), 4'b1100);
    host_pattern = 4'b0101;
    rst = 1'b1;
    #1;
    check("arst_pattern", 32'(pattern), 4'b0101);
    check("arst_ov", 32'(overflow), 0);
    check("arst_ur", 32'(underrun), 0);
    check("arst_len", 32'(seq_len), 0);
    cyc();
    rst = 1'b0;
    drive(MODE_INPUT, 4'b0000);
    cyc();

`ifdef AUTOPLAY_ERR_INJECT_EN
    err_inject = 1'b1;
    err_index = 6'd1;
    drive(MODE_PLAY, 4'b0001);
    cyc();
    drive(MODE_PLAY, 4'b0100);
    cyc();
    drive(MODE_REPEAT, 4'b0000);
    check("inj_rep0", 32'(pattern), 4'b0001);
    cyc();
    check("inj_rep1", 32'(pattern), 4'b0101);
    cyc();
    err_inject = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
